clk_stage_sequencer: RTL and testbench

Multi-cycle stage sequencer driven by the system clock `CLK`. It steps the processor datapath through fetch, decode, execute, memory and writeback by issuing one-hot stage enables. It supports free-run, single-step and halt control, memory-wait stalls with a stall timeout, and a retired-instruction counter. It sits between the clock generator and the datapath/control unit.

---
 rtl/clk_stage_sequencer.sv | 150 +++++++++++++++
 tb/tb_clk_stage_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_stage_sequencer.sv
// Five-stage instruction sequencer: one-hot stage enables with run/step/halt
// control, memory-wait stalls with timeout, and a retired-instruction counter.
module clk_stage_sequencer #(
   parameter int unsigned CNT_WIDTH   = 32,
   parameter int unsigned STALL_LIMIT = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_run,
   input  logic                 i_step_req,
   input  logic                 i_halt_req,
   input  logic                 i_stall,
   output logic [4:0]           o_stage_en_c,
   output logic                 o_halted,
   output logic                 o_step_ack,
   output logic                 o_stall_err,
   output logic [CNT_WIDTH-1:0] o_instr_cnt
);

   localparam int unsigned STALL_W = 8;
   localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);

   typedef enum logic [2:0] {
      S_HALT   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXE    = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5
   } state_t;

   state_t                r_state;
   logic                  r_mode_step;
   logic                  r_halt_pend;
   logic [STALL_W-1:0]    r_stall_cnt;
   logic                  r_step_prev;
   logic                  r_step_ack;
   logic                  r_stall_err;
   logic                  r_halted;
   logic [CNT_WIDTH-1:0]  r_instr_cnt;

   state_t                w_state_nxt;
   logic                  w_mode_step_nxt;
   logic                  w_halt_pend_nxt;
   logic [STALL_W-1:0]    w_stall_cnt_nxt;
   logic                  w_step_ack_nxt;
   logic                  w_stall_err_nxt;
   logic [CNT_WIDTH-1:0]  w_instr_cnt_nxt;
   logic [4:0]            w_stage_en;

   // State and control registers
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state     <= S_HALT;
         r_mode_step <= 1'b0;
         r_halt_pend <= 1'b0;
         r_stall_cnt <= '0;
         r_step_prev <= 1'b0;
         r_step_ack  <= 1'b0;
         r_stall_err <= 1'b0;
         r_halted    <= 1'b1;
         r_instr_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_mode_step <= w_mode_step_nxt;
         r_halt_pend <= w_halt_pend_nxt;
         r_stall_cnt <= w_stall_cnt_nxt;
         r_step_prev <= i_step_req;
         r_step_ack  <= w_step_ack_nxt;
         r_stall_err <= w_stall_err_nxt;
         r_halted    <= (w_state_nxt == S_HALT);
         r_instr_cnt <= w_instr_cnt_nxt;
      end
   end

   // Next-state, counters and stage decode
   always_comb begin
      w_state_nxt     = r_state;
      w_mode_step_nxt = r_mode_step;
      w_halt_pend_nxt = r_halt_pend;
      w_stall_cnt_nxt = r_stall_cnt;
      w_step_ack_nxt  = 1'b0;
      w_stall_err_nxt = r_stall_err;
      w_instr_cnt_nxt = r_instr_cnt;
      w_stage_en      = 5'b00000;

      if (r_state == S_HALT) begin
         w_stall_cnt_nxt = '0;
         w_halt_pend_nxt = 1'b0;
         if (!r_stall_err) begin
            if (i_run) begin
               w_state_nxt     = S_FETCH;
               w_mode_step_nxt = 1'b0;
            end else if (i_step_req && !r_step_prev) begin
               w_state_nxt     = S_FETCH;
               w_mode_step_nxt = 1'b1;
            end
         end
      end else begin
         w_halt_pend_nxt = r_halt_pend | i_halt_req;
         if (i_stall) begin
            w_stall_cnt_nxt = r_stall_cnt + STALL_W'(1);
            if ((STALL_LIMIT != 0) && (w_stall_cnt_nxt == STALL_MAX)) begin
               w_stall_err_nxt = 1'b1;
               w_state_nxt     = S_HALT;
               w_halt_pend_nxt = 1'b0;
            end
         end else begin
            w_stall_cnt_nxt = '0;
            case (r_state)
               S_FETCH: begin
                  w_stage_en  = 5'b00001;
                  w_state_nxt = S_DECODE;
               end
               S_DECODE: begin
                  w_stage_en  = 5'b00010;
                  w_state_nxt = S_EXE;
               end
               S_EXE: begin
                  w_stage_en  = 5'b00100;
                  w_state_nxt = S_MEM;
               end
               S_MEM: begin
                  w_stage_en  = 5'b01000;
                  w_state_nxt = S_WB;
               end
               S_WB: begin
                  w_stage_en      = 5'b10000;
                  w_instr_cnt_nxt = r_instr_cnt + CNT_WIDTH'(1);
                  if (r_mode_step || w_halt_pend_nxt || !i_run) begin
                     w_state_nxt     = S_HALT;
                     w_halt_pend_nxt = 1'b0;
                     w_step_ack_nxt  = r_mode_step;
                  end else begin
                     w_state_nxt = S_FETCH;
                  end
               end
               default: w_state_nxt = S_HALT;
            endcase
         end
      end
   end

   assign o_stage_en_c = w_stage_en;
   assign o_halted     = r_halted;
   assign o_step_ack   = r_step_ack;
   assign o_stall_err  = r_stall_err;
   assign o_instr_cnt  = r_instr_cnt;

endmodule

// File: tb/tb_clk_stage_sequencer.sv
// Directed bench for clk_stage_sequencer; a second instance with a 4-bit
// counter shares the stimulus to exercise counter wrap.
module tb_clk_stage_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic        step_req;
   logic        halt_req;
   logic        stall;
   logic [4:0]  stage_en;
   logic        halted;
   logic        step_ack;
   logic        stall_err;
   logic [31:0] instr_cnt;
   logic [4:0]  stage_en4;
   logic        halted4;
   logic        step_ack4;
   logic        stall_err4;
   logic [3:0]  instr_cnt4;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_cnt  = 0;

   always #5 clk = ~clk;

   clk_stage_sequencer #(.CNT_WIDTH(32), .STALL_LIMIT(16)) dut (
      .i_clk(clk), .i_rst(rst), .i_run(run), .i_step_req(step_req),
      .i_halt_req(halt_req), .i_stall(stall), .o_stage_en_c(stage_en),
      .o_halted(halted), .o_step_ack(step_ack), .o_stall_err(stall_err),
      .o_instr_cnt(instr_cnt)
   );

   clk_stage_sequencer #(.CNT_WIDTH(4), .STALL_LIMIT(16)) dut4 (
      .i_clk(clk), .i_rst(rst), .i_run(run), .i_step_req(step_req),
      .i_halt_req(halt_req), .i_stall(stall), .o_stage_en_c(stage_en4),
      .o_halted(halted4), .o_step_ack(step_ack4), .o_stall_err(stall_err4),
      .o_instr_cnt(instr_cnt4)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic step_clk;
      @(posedge clk);
      #1;
   endtask

   // Stage enable expected for the c-th cycle of an instruction starting at 1
   function automatic logic [31:0] onehot(input int idx);
      return 32'(1 << idx);
   endfunction

   initial begin
      rst = 1'b0; run = 1'b0; step_req = 1'b0; halt_req = 1'b0; stall = 1'b0;
      step_clk();
      step_clk();

      // reset asserted mid-EXE
      rst = 1'b1; run = 1'b1;
      step_clk();
      step_clk();
      step_clk();
      #1 check("pre_rst_exe", 32'(stage_en), 32'h4);
      rst = 1'b0;
      step_clk();
      #1;
      check("rst_halted", 32'(halted), 32'h1);
      check("rst_stage", 32'(stage_en), 32'h0);
      check("rst_cnt", instr_cnt, 32'h0);
      check("rst_err", 32'(stall_err), 32'h0);
      check("rst_ack", 32'(step_ack), 32'h0);
      step_clk();
      rst = 1'b1; run = 1'b0;
      step_clk();

      // free run: three instructions, RUN dropped during the third WB
      run = 1'b1;
      #1 check("fr_halt0", 32'(halted), 32'h1);
      step_clk();
      for (int i = 0; i < 15; i++) begin
         if (i == 14) run = 1'b0;
         #1;
         check("fr_stage", 32'(stage_en), onehot(i % 5));
         check("fr_ack", 32'(step_ack), 32'h0);
         check("fr_halted", 32'(halted), 32'h0);
         step_clk();
      end
      exp_cnt = 3;
      #1;
      check("fr_end_halted", 32'(halted), 32'h1);
      check("fr_end_cnt", instr_cnt, 32'(exp_cnt));
      check("fr_end_ack", 32'(step_ack), 32'h0);
      check("fr_end_cnt4", 32'(instr_cnt4), 32'(exp_cnt % 16));

      // single step with STEP_REQ held for 20 cycles
      for (int c = 0; c < 20; c++) begin
         step_req = 1'b1;
         if (c == 6) exp_cnt = 4;
         #1;
         check("st_stage", 32'(stage_en), (c >= 1 && c <= 5) ? onehot(c - 1) : 32'h0);
         check("st_ack", 32'(step_ack), (c == 6) ? 32'h1 : 32'h0);
         check("st_halted", 32'(halted), (c == 0 || c >= 6) ? 32'h1 : 32'h0);
         if (c == 6) check("st_cnt", instr_cnt, 32'(exp_cnt));
         step_clk();
      end
      step_req = 1'b0;
      #1 check("st_cnt_final", instr_cnt, 32'(exp_cnt));

      // three stall cycles in MEM stretch the instruction to 8 cycles
      for (int c = 0; c < 9; c++) begin
         logic [4:0] exp_st [9];
         exp_st = '{5'h00, 5'h01, 5'h02, 5'h04, 5'h00, 5'h00, 5'h00, 5'h08, 5'h10};
         run   = (c < 8);
         stall = (c >= 4 && c <= 6);
         #1 check("sl_stage", 32'(stage_en), 32'(exp_st[c]));
         step_clk();
      end
      stall = 1'b0;
      exp_cnt = 5;
      #1;
      check("sl_halted", 32'(halted), 32'h1);
      check("sl_cnt", instr_cnt, 32'(exp_cnt));

      // stall timeout in DECODE
      for (int c = 0; c < 18; c++) begin
         run   = 1'b1;
         stall = (c >= 2);
         #1;
         check("to_stage", 32'(stage_en), (c == 1) ? 32'h1 : 32'h0);
         if (c >= 1) check("to_err_low", 32'(stall_err), 32'h0);
         if (c >= 1) check("to_halted_low", 32'(halted), 32'h0);
         step_clk();
      end
      #1;
      check("to_err", 32'(stall_err), 32'h1);
      check("to_halted", 32'(halted), 32'h1);
      check("to_cnt", instr_cnt, 32'(exp_cnt));
      check("to_ack", 32'(step_ack), 32'h0);
      stall = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step_clk();
         #1;
         check("to_stuck_halted", 32'(halted), 32'h1);
         check("to_stuck_stage", 32'(stage_en), 32'h0);
      end
      rst = 1'b0;
      step_clk();
      #1;
      check("to_rst_err", 32'(stall_err), 32'h0);
      check("to_rst_cnt", instr_cnt, 32'h0);
      rst = 1'b1; run = 1'b0; exp_cnt = 0;
      step_clk();

      // HALT_REQ pulsed in DECODE while RUN stays high
      for (int c = 0; c < 6; c++) begin
         run      = 1'b1;
         halt_req = (c == 2);
         #1 check("hr_stage", 32'(stage_en), (c == 0) ? 32'h0 : onehot(c - 1));
         step_clk();
      end
      halt_req = 1'b0;
      exp_cnt = 1;
      #1;
      check("hr_halted", 32'(halted), 32'h1);
      check("hr_cnt", instr_cnt, 32'(exp_cnt));
      run = 1'b0;
      step_clk();

      // 16 free-run instructions wrap the 4-bit counter
      rst = 1'b0;
      step_clk();
      rst = 1'b1;
      step_clk();
      run = 1'b1;
      step_clk();
      for (int n = 0; n < 80; n++) begin
         if (n == 79) run = 1'b0;
         #1;
         if (n == 75) begin
            check("wr_cnt4_15", 32'(instr_cnt4), 32'hf);
            check("wr_cnt_15", instr_cnt, 32'd15);
         end
         check("wr_ack", 32'(step_ack4), 32'h0);
         step_clk();
      end
      #1;
      check("wr_cnt4_0", 32'(instr_cnt4), 32'h0);
      check("wr_cnt_16", instr_cnt, 32'd16);
      check("wr_halted", 32'(halted4), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
